multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32 subset core: add, sub, and, or, xor, addi, srai, lw, sw, beq. It sequences fetch, decode, execute, memory and writeback over the shared ALU/register-file/memory datapath. It handshakes with instruction and data memories. It drives the immediate-generator select with {funct3, opcode} of the latched instruction, and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter
TIMEOUT, 255, max wait cycles on any memory handshake before trap; 0 = disabled

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-low reset
start_i  input  1  leave IDLE and begin fetching
stop_i  input  1  level; return to IDLE at next retire
instr_i  input  32  instruction from imem, valid with imem_ready_i
imem_ready_i  input  1  imem data valid this cycle
dmem_ready_i  input  1  dmem access complete this cycle
zero_i  input  1  ALU zero flag
imem_re_o  output  1  instruction read request
ir_we_o  output  1  load IR and old_pc (1-cycle pulse)
pc_we_o  output  1  PC write enable
pc_src_o  output  1  0 = PC+4, 1 = old_pc + imm
imm_op_o  output  10  {funct3, opcode} of latched instruction, to sign extender
alu_ctrl_o  output  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sra
alu_src_o  output  1  0 = rs2, 1 = imm
dmem_re_o  output  1  data read request
dmem_we_o  output  1  data write request
reg_we_o  output  1  register-file write enable
wb_sel_o  output  1  0 = ALU result, 1 = dmem data
busy_o  output  1  high in every state except IDLE and TRAP
trap_o  output  1  high in TRAP
trap_cause_o  output  2  01 illegal, 10 imem timeout, 11 dmem timeout
retired_o  output  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_i low at a clock edge): state IDLE; every output 0; internal instruction register 0; wait counter 0. Takes effect from any state, including a pending memory handshake. No request stays asserted after the reset edge.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE: all outputs 0 except retired_o, which holds. start_i=1 -> FETCH.
- FETCH: imem_re_o=1 until imem_ready_i.
  - On the ready cycle: ir_we_o=1, pc_we_o=1, pc_src_o=0; latch instr_i; -> DECODE.
- DECODE: 1 cycle.
  - Legal: opcode 0110011 with f3/f7 000/0000000 add, 000/0100000 sub, 111/0 and, 110/0 or, 100/0 xor; 0010011 f3 000 addi; 0010011 f3 101 f7 0100000 srai; 0000011 f3 010 lw; 0100011 f3 010 sw; 1100011 f3 000 beq.
  - Any other encoding -> TRAP with cause 01.
  - Otherwise -> EXEC.
- imm_op_o = {instr[14:12], instr[6:0]} of the latched instruction. It is driven from DECODE through WB and is 0 elsewhere.
- EXEC: 1 cycle.
  - alu_src_o=1 for addi, srai, lw, sw; 0 otherwise.
  - alu_ctrl_o: add for addi, lw and sw; sub for beq; sra for srai.
  - R/I-type -> WB. lw/sw -> MEM.
  - beq: pc_we_o = zero_i (Mealy), pc_src_o=1; instruction retires.
- MEM: lw holds dmem_re_o=1, sw holds dmem_we_o=1, until dmem_ready_i.
  - On ready: lw -> WB (wb_sel_o=1 in WB); sw retires.
- WB: 1 cycle; reg_we_o=1 unless rd (instr[11:7]) = 0; instruction retires.
- Retire: retired_o increments by 1, wrapping at 2^CNT_W. Next state is IDLE if stop_i=1, else FETCH.
- Latency with zero-wait memory: R/I-type 4 cycles, lw 5, sw 4, beq 3. Each memory wait cycle adds 1.
- Timeout: the wait counter counts consecutive FETCH or MEM cycles without ready and clears on ready or on state change.
  - With TIMEOUT>0, reaching TIMEOUT waits -> TRAP, cause 10 for FETCH, 11 for MEM.
  - A ready arriving in the same cycle as the limit wins: no trap.
- TRAP: all requests and enables 0; trap_o=1; trap_cause_o held; start_i ignored. Only reset exits.
- start_i outside IDLE is ignored. stop_i is sampled only at retire.

Test Plan:
- Reset, start_i pulse, addi x1,x0,5 (0x00500093), imem_ready_i same cycle -> ir_we_o pulse in FETCH, imm_op_o=0000010011, EXEC alu_ctrl_o=0000 alu_src_o=1, WB reg_we_o=1; retired_o=1 four cycles after start.
- lw x2,4(x1) (0x0040A103), dmem_ready_i after 3 waits -> dmem_re_o high 4 cycles, then WB with wb_sel_o=1 and reg_we_o=1; total 8 cycles.
- beq x0,x0,8 (0x00000463): zero_i=1 -> EXEC pc_we_o=1 pc_src_o=1. zero_i=0 -> no pc_we_o in EXEC. Either case -> FETCH next; retired_o +1.
- instr_i=0xFFFFFFFF -> DECODE then TRAP; trap_o=1, trap_cause_o=01, busy_o=0. Later start_i pulses are ignored until reset.
- TIMEOUT=4, imem_ready_i held 0 -> 4 FETCH cycles with imem_re_o=1, then TRAP with cause 10. Repeat with ready on the 4th wait cycle -> no trap.
- rst_i low for one edge during sw MEM wait -> next cycle IDLE, dmem_we_o=0, retired_o=0, busy_o=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multi-cycle control FSM for an RV32 subset core with memory
//            handshakes, timeout traps and a retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [31:0]      instr_i,
    input  logic             imem_ready_i,
    input  logic             dmem_ready_i,
    input  logic             zero_i,
    output logic             imem_re_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic             pc_src_o,
    output logic [9:0]       imm_op_o,
    output logic [3:0]       alu_ctrl_o,
    output logic             alu_src_o,
    output logic             dmem_re_o,
    output logic             dmem_we_o,
    output logic             reg_we_o,
    output logic             wb_sel_o,
    output logic             busy_o,
    output logic             trap_o,
    output logic [1:0]       trap_cause_o,
    output logic [CNT_W-1:0] retired_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        K_ADD     = 4'd0,
        K_SUB     = 4'd1,
        K_AND     = 4'd2,
        K_OR      = 4'd3,
        K_XOR     = 4'd4,
        K_ADDI    = 4'd5,
        K_SRAI    = 4'd6,
        K_LW      = 4'd7,
        K_SW      = 4'd8,
        K_BEQ     = 4'd9,
        K_ILLEGAL = 4'd10
    } kind_t;

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    localparam logic [3:0] c_alu_add = 4'b0000;
    localparam logic [3:0] c_alu_sub = 4'b0001;
    localparam logic [3:0] c_alu_and = 4'b0010;
    localparam logic [3:0] c_alu_or  = 4'b0011;
    localparam logic [3:0] c_alu_xor = 4'b0100;
    localparam logic [3:0] c_alu_sra = 4'b0101;

    localparam logic [1:0] c_cause_illegal = 2'b01;
    localparam logic [1:0] c_cause_imem    = 2'b10;
    localparam logic [1:0] c_cause_dmem    = 2'b11;

    // The counter only ever needs to hold TIMEOUT-1 before the limit fires.
    localparam int                  c_wait_w     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_wait_w-1:0] c_wait_limit = c_wait_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t              r_state;
    state_t              w_next_state;
    logic [31:0]         r_ir;
    logic [c_wait_w-1:0] r_wait;
    logic [c_wait_w-1:0] w_wait_next;
    logic [1:0]          r_cause;
    logic [1:0]          w_cause_next;
    logic [CNT_W-1:0]    r_retired;
    logic                w_retire;
    logic                w_timeout_hit;
    kind_t               w_kind;
    logic                w_unused_ir;

    function automatic kind_t f_decode(input logic [31:0] ins);
        kind_t k;
        k = K_ILLEGAL;
        case (ins[6:0])
            c_op_r: begin
                case ({ins[14:12], ins[31:25]})
                    {3'b000, 7'b0000000}: k = K_ADD;
                    {3'b000, 7'b0100000}: k = K_SUB;
                    {3'b111, 7'b0000000}: k = K_AND;
                    {3'b110, 7'b0000000}: k = K_OR;
                    {3'b100, 7'b0000000}: k = K_XOR;
                    default:              k = K_ILLEGAL;
                endcase
            end
            c_op_imm: begin
                if (ins[14:12] == 3'b000)
                    k = K_ADDI;
                else if (ins[14:12] == 3'b101 && ins[31:25] == 7'b0100000)
                    k = K_SRAI;
            end
            c_op_load:   if (ins[14:12] == 3'b010) k = K_LW;
            c_op_store:  if (ins[14:12] == 3'b010) k = K_SW;
            c_op_branch: if (ins[14:12] == 3'b000) k = K_BEQ;
            default:     k = K_ILLEGAL;
        endcase
        return k;
    endfunction

    assign w_kind        = f_decode(r_ir);
    assign w_timeout_hit = (TIMEOUT != 0) && (r_wait == c_wait_limit);
    // Register and shamt fields are consumed by the datapath, not the controller.
    assign w_unused_ir   = ^r_ir[24:15];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state   <= S_IDLE;
            r_ir      <= '0;
            r_wait    <= '0;
            r_cause   <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            r_wait  <= w_wait_next;
            r_cause <= w_cause_next;
            if (ir_we_o)
                r_ir <= instr_i;
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_wait_next  = '0;
        w_cause_next = r_cause;
        w_retire     = 1'b0;
        imem_re_o    = 1'b0;
        ir_we_o      = 1'b0;
        pc_we_o      = 1'b0;
        pc_src_o     = 1'b0;
        imm_op_o     = '0;
        alu_ctrl_o   = c_alu_add;
        alu_src_o    = 1'b0;
        dmem_re_o    = 1'b0;
        dmem_we_o    = 1'b0;
        reg_we_o     = 1'b0;
        wb_sel_o     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_i)
                    w_next_state = S_FETCH;
            end
            S_FETCH: begin
                imem_re_o = 1'b1;
                if (imem_ready_i) begin
                    ir_we_o      = 1'b1;
                    pc_we_o      = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_timeout_hit) begin
                    w_next_state = S_TRAP;
                    w_cause_next = c_cause_imem;
                end else begin
                    w_wait_next = r_wait + c_wait_w'(1);
                end
            end
            S_DECODE: begin
                imm_op_o = {r_ir[14:12], r_ir[6:0]};
                if (w_kind == K_ILLEGAL) begin
                    w_next_state = S_TRAP;
                    w_cause_next = c_cause_illegal;
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                imm_op_o  = {r_ir[14:12], r_ir[6:0]};
                alu_src_o = (w_kind == K_ADDI) || (w_kind == K_SRAI) ||
                            (w_kind == K_LW)   || (w_kind == K_SW);
                case (w_kind)
                    K_SUB, K_BEQ: alu_ctrl_o = c_alu_sub;
                    K_AND:        alu_ctrl_o = c_alu_and;
                    K_OR:         alu_ctrl_o = c_alu_or;
                    K_XOR:        alu_ctrl_o = c_alu_xor;
                    K_SRAI:       alu_ctrl_o = c_alu_sra;
                    default:      alu_ctrl_o = c_alu_add;
                endcase
                case (w_kind)
                    K_LW, K_SW: w_next_state = S_MEM;
                    K_BEQ: begin
                        pc_we_o  = zero_i;
                        pc_src_o = 1'b1;
                        w_retire = 1'b1;
                    end
                    default:    w_next_state = S_WB;
                endcase
            end
            S_MEM: begin
                imm_op_o  = {r_ir[14:12], r_ir[6:0]};
                dmem_re_o = (w_kind == K_LW);
                dmem_we_o = (w_kind == K_SW);
                if (dmem_ready_i) begin
                    if (w_kind == K_LW)
                        w_next_state = S_WB;
                    else
                        w_retire = 1'b1;
                end else if (w_timeout_hit) begin
                    w_next_state = S_TRAP;
                    w_cause_next = c_cause_dmem;
                end else begin
                    w_wait_next = r_wait + c_wait_w'(1);
                end
            end
            S_WB: begin
                imm_op_o = {r_ir[14:12], r_ir[6:0]};
                reg_we_o = (r_ir[11:7] != 5'd0);
                wb_sel_o = (w_kind == K_LW);
                w_retire = 1'b1;
            end
            S_TRAP: begin
                w_next_state = S_TRAP;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        if (w_retire)
            w_next_state = stop_i ? S_IDLE : S_FETCH;
    end

    assign busy_o       = (r_state != S_IDLE) && (r_state != S_TRAP);
    assign trap_o       = (r_state == S_TRAP);
    assign trap_cause_o = r_cause;
    assign retired_o    = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Self-checking bench for multicycle_ctrl: vector table, corner
//            sequences and randomized programs against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 4;

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] LW   = 32'h0040A103;
    localparam logic [31:0] BEQ  = 32'h00000463;
    localparam logic [31:0] BAD  = 32'hFFFFFFFF;
    localparam logic [31:0] SW   = {7'b0, 5'd2, 5'd1, 3'b010, 5'b01000, 7'b0100011};

    localparam logic [9:0] IMM_ADDI = 10'b000_0010011;
    localparam logic [9:0] IMM_LW   = 10'b010_0000011;
    localparam logic [9:0] IMM_BEQ  = 10'b000_1100011;
    localparam logic [9:0] IMM_BAD  = 10'b111_1111111;

    // status nibble {busy, trap, cause[1:0]}
    localparam logic [3:0]  ST_B = 4'b1000;
    localparam logic [26:0] Z    = '0;

    logic             clk = 1'b0;
    logic             rst_i = 1'b0;
    logic             start_i = 1'b0, stop_i = 1'b0;
    logic [31:0]      instr_i = '0;
    logic             imem_ready_i = 1'b0, dmem_ready_i = 1'b0, zero_i = 1'b0;
    logic             imem_re_o, ir_we_o, pc_we_o, pc_src_o;
    logic [9:0]       imm_op_o;
    logic [3:0]       alu_ctrl_o;
    logic             alu_src_o, dmem_re_o, dmem_we_o, reg_we_o, wb_sel_o;
    logic             busy_o, trap_o;
    logic [1:0]       trap_cause_o;
    logic [CNT_W-1:0] retired_o;
    logic [26:0]      act_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .instr_i(instr_i), .imem_ready_i(imem_ready_i), .dmem_ready_i(dmem_ready_i),
        .zero_i(zero_i), .imem_re_o(imem_re_o), .ir_we_o(ir_we_o), .pc_we_o(pc_we_o),
        .pc_src_o(pc_src_o), .imm_op_o(imm_op_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_src_o(alu_src_o), .dmem_re_o(dmem_re_o), .dmem_we_o(dmem_we_o),
        .reg_we_o(reg_we_o), .wb_sel_o(wb_sel_o), .busy_o(busy_o), .trap_o(trap_o),
        .trap_cause_o(trap_cause_o), .retired_o(retired_o)
    );

    assign act_o = {imem_re_o, ir_we_o, pc_we_o, pc_src_o, imm_op_o, alu_ctrl_o,
                    alu_src_o, dmem_re_o, dmem_we_o, reg_we_o, wb_sel_o,
                    busy_o, trap_o, trap_cause_o};

    // hs = {imem_re, ir_we, pc_we, pc_src}; mw = {alu_src, dmem_re, dmem_we, reg_we, wb_sel}
    function automatic logic [26:0] mk(input logic [3:0] hs, input logic [9:0] imm,
                                       input logic [3:0] alu, input logic [4:0] mw,
                                       input logic [3:0] st);
        return {hs, imm, alu, mw, st};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
        imem_ready_i = 1'b0; dmem_ready_i = 1'b0; zero_i = 1'b0;
        tick();
        rst_i = 1'b1;
    endtask

    typedef struct {
        logic        rst_n, start, stop;
        logic [31:0] instr;
        logic        iready, dready, zero, check;
        logic [26:0] exp_o;
        logic [31:0] exp_ret;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst_n, input logic start, input logic stop,
                       input logic [31:0] instr, input logic ir, input logic dr,
                       input logic z, input logic ck, input logic [26:0] e,
                       input logic [31:0] r);
        vec_t v;
        v.rst_n = rst_n; v.start = start; v.stop = stop; v.instr = instr;
        v.iready = ir; v.dready = dr; v.zero = z; v.check = ck;
        v.exp_o = e; v.exp_ret = r;
        tbl.push_back(v);
    endtask

    // Instruction kinds: 0 add 1 sub 2 and 3 or 4 xor 5 addi 6 srai 7 lw 8 sw 9 beq
    function automatic logic [31:0] enc(input int k, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [11:0] imm);
        case (k)
            0: return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            1: return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            2: return {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
            3: return {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
            4: return {7'b0000000, rs2, rs1, 3'b100, rd, 7'b0110011};
            5: return {imm, rs1, 3'b000, rd, 7'b0010011};
            6: return {7'b0100000, rs2, rs1, 3'b101, rd, 7'b0010011};
            7: return {imm, rs1, 3'b010, rd, 7'b0000011};
            8: return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            default: return {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'b1100011};
        endcase
    endfunction

    function automatic logic [3:0] exp_alu(input int k);
        case (k)
            1, 9:    return 4'b0001;
            2:       return 4'b0010;
            3:       return 4'b0011;
            4:       return 4'b0100;
            6:       return 4'b0101;
            default: return 4'b0000;
        endcase
    endfunction

    // Back-to-back random program; each instruction's per-output activity is
    // predicted from its kind, wait counts and branch outcome.
    task automatic run_random(input int n_instr);
        int          model_ret;
        model_ret = 0;
        do_reset();
        start_i = 1'b1;
        tick();
        for (int n = 0; n < n_instr; n++) begin
            int          k, kw, mw, lat;
            int          c_ire, c_irwe, c_pcwe, c_pcsrc, c_dre, c_dwe;
            int          c_regwe, c_wbsel, c_alusrc, c_busy, c_imm, c_trap;
            logic        z, is_mem;
            logic [4:0]  rd;
            logic [31:0] ins;
            logic [3:0]  alu_seen;
            logic [9:0]  imm_seen;
            k   = $urandom_range(0, 9);
            kw  = $urandom_range(0, TIMEOUT - 1);
            mw  = $urandom_range(0, TIMEOUT - 1);
            z   = 1'($urandom_range(0, 1));
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ins = enc(k, rd, 5'($urandom), 5'($urandom), 12'($urandom));
            is_mem = (k == 7) || (k == 8);
            lat = kw + ((k == 9) ? 3 : (k == 7) ? 5 : 4) + (is_mem ? mw : 0);
            c_ire = 0; c_irwe = 0; c_pcwe = 0; c_pcsrc = 0; c_dre = 0; c_dwe = 0;
            c_regwe = 0; c_wbsel = 0; c_alusrc = 0; c_busy = 0; c_imm = 0; c_trap = 0;
            alu_seen = 'x; imm_seen = 'x;
            for (int j = 0; j < lat; j++) begin
                instr_i      = ins;
                zero_i       = z;
                stop_i       = (n == n_instr - 1);
                start_i      = 1'($urandom_range(0, 1));
                imem_ready_i = (j == kw) || (j > kw && $urandom_range(0, 1) == 1);
                dmem_ready_i = (is_mem && j == kw + 3 + mw) ||
                               (j < kw + 3 && $urandom_range(0, 1) == 1);
                @(negedge clk);
                c_ire += int'(imem_re_o);  c_irwe += int'(ir_we_o);
                c_pcwe += int'(pc_we_o);   c_pcsrc += int'(pc_src_o);
                c_dre += int'(dmem_re_o);  c_dwe += int'(dmem_we_o);
                c_regwe += int'(reg_we_o); c_wbsel += int'(wb_sel_o);
                c_alusrc += int'(alu_src_o); c_busy += int'(busy_o);
                c_imm += int'(imm_op_o != 10'd0); c_trap += int'(trap_o);
                if (j == kw + 2) begin
                    alu_seen = alu_ctrl_o;
                    imm_seen = imm_op_o;
                end
                tick();
            end
            model_ret++;
            chk($sformatf("rnd%0d k%0d imem_re cycles", n, k), c_ire, kw + 1);
            chk($sformatf("rnd%0d k%0d ir_we pulses", n, k), c_irwe, 1);
            chk($sformatf("rnd%0d k%0d pc_we pulses", n, k), c_pcwe, 1 + int'(k == 9 && z));
            chk($sformatf("rnd%0d k%0d pc_src cycles", n, k), c_pcsrc, int'(k == 9));
            chk($sformatf("rnd%0d k%0d dmem_re cycles", n, k), c_dre, (k == 7) ? mw + 1 : 0);
            chk($sformatf("rnd%0d k%0d dmem_we cycles", n, k), c_dwe, (k == 8) ? mw + 1 : 0);
            chk($sformatf("rnd%0d k%0d reg_we pulses", n, k), c_regwe, int'(k <= 7 && rd != 5'd0));
            chk($sformatf("rnd%0d k%0d wb_sel cycles", n, k), c_wbsel, int'(k == 7));
            chk($sformatf("rnd%0d k%0d alu_src cycles", n, k), c_alusrc, int'(k >= 5 && k <= 8));
            chk($sformatf("rnd%0d k%0d busy cycles", n, k), c_busy, lat);
            chk($sformatf("rnd%0d k%0d imm_op cycles", n, k), c_imm, lat - kw - 1);
            chk($sformatf("rnd%0d k%0d trap cycles", n, k), c_trap, 0);
            chk($sformatf("rnd%0d k%0d exec alu_ctrl", n, k), alu_seen, exp_alu(k));
            chk($sformatf("rnd%0d k%0d exec imm_op", n, k), imm_seen, {ins[14:12], ins[6:0]});
            chk($sformatf("rnd%0d k%0d retired", n, k), retired_o, model_ret);
        end
        start_i = 1'b0; stop_i = 1'b0; imem_ready_i = 1'b0; dmem_ready_i = 1'b0;
        @(negedge clk);
        chk("rnd idle after stop", act_o, Z);
        chk("rnd final retired", retired_o, model_ret);
        tick();
    endtask

    initial begin
        // rst_n start stop instr ir dr z check expected-outputs retired
        add(0, 0, 0, 0,    0, 0, 0, 0, Z, 0);
        add(1, 0, 0, 0,    0, 0, 0, 1, Z, 0);
        add(1, 1, 0, 0,    0, 0, 0, 1, Z, 0);
        add(1, 0, 0, ADDI, 1, 0, 0, 1, mk(4'b1110, 10'd0, 4'd0, 5'b00000, ST_B), 0);
        add(1, 0, 0, 0,    0, 0, 0, 1, mk(4'b0000, IMM_ADDI, 4'd0, 5'b00000, ST_B), 0);
        add(1, 0, 0, 0,    0, 0, 0, 1, mk(4'b0000, IMM_ADDI, 4'd0, 5'b10000, ST_B), 0);
        add(1, 0, 1, 0,    0, 0, 0, 1, mk(4'b0000, IMM_ADDI, 4'd0, 5'b00010, ST_B), 0);
        add(1, 1, 0, 0,    0, 0, 0, 1, Z, 1);
        add(1, 0, 0, LW,   1, 0, 0, 1, mk(4'b1110, 10'd0, 4'd0, 5'b00000, ST_B), 1);
        add(1, 0, 0, 0,    0, 0, 0, 1, mk(4'b0000, IMM_LW, 4'd0, 5'b00000, ST_B), 1);
        add(1, 0, 0, 0,    0, 0, 0, 1, mk(4'b0000, IMM_LW, 4'd0, 5'b10000, ST_B), 1);
        add(1, 0, 0, 0,    0, 0, 0, 1, mk(4'b0000, IMM_LW, 4'd0, 5'b01000, ST_B), 1);
        add(1, 0, 0, 0,    0, 0, 0, 1, mk(4'b0000, IMM_LW, 4'd0, 5'b01000, ST_B), 1);
        add(1, 0, 0, 0,    0, 0, 0, 1, mk(4'b0000, IMM_LW, 4'd0, 5'b01000, ST_B), 1);
        add(1, 0, 0, 0,    0, 1, 0, 1, mk(4'b0000, IMM_LW, 4'd0, 5'b01000, ST_B), 1);
        add(1, 0, 1, 0,    0, 0, 0, 1, mk(4'b0000, IMM_LW, 4'd0, 5'b00011, ST_B), 1);
        add(1, 1, 0, 0,    0, 0, 0, 1, Z, 2);
        add(1, 0, 0, BEQ,  1, 0, 0, 1, mk(4'b1110, 10'd0, 4'd0, 5'b00000, ST_B), 2);
        add(1, 0, 0, 0,    0, 0, 0, 1, mk(4'b0000, IMM_BEQ, 4'd0, 5'b00000, ST_B), 2);
        add(1, 0, 0, 0,    0, 0, 1, 1, mk(4'b0011, IMM_BEQ, 4'd1, 5'b00000, ST_B), 2);
        add(1, 0, 0, BEQ,  1, 0, 0, 1, mk(4'b1110, 10'd0, 4'd0, 5'b00000, ST_B), 3);
        add(1, 0, 0, 0,    0, 0, 0, 1, mk(4'b0000, IMM_BEQ, 4'd0, 5'b00000, ST_B), 3);
        add(1, 0, 1, 0,    0, 0, 0, 1, mk(4'b0001, IMM_BEQ, 4'd1, 5'b00000, ST_B), 3);
        add(1, 1, 0, 0,    0, 0, 0, 1, Z, 4);
        add(1, 0, 0, BAD,  1, 0, 0, 1, mk(4'b1110, 10'd0, 4'd0, 5'b00000, ST_B), 4);
        add(1, 0, 0, 0,    0, 0, 0, 1, mk(4'b0000, IMM_BAD, 4'd0, 5'b00000, ST_B), 4);
        add(1, 1, 0, 0,    0, 0, 0, 1, mk(4'b0000, 10'd0, 4'd0, 5'b00000, 4'b0101), 4);
        add(1, 0, 0, 0,    0, 0, 0, 1, mk(4'b0000, 10'd0, 4'd0, 5'b00000, 4'b0101), 4);
        add(1, 1, 0, 0,    0, 0, 0, 1, mk(4'b0000, 10'd0, 4'd0, 5'b00000, 4'b0101), 4);

        foreach (tbl[i]) begin
            rst_i = tbl[i].rst_n; start_i = tbl[i].start; stop_i = tbl[i].stop;
            instr_i = tbl[i].instr; imem_ready_i = tbl[i].iready;
            dmem_ready_i = tbl[i].dready; zero_i = tbl[i].zero;
            @(negedge clk);
            if (tbl[i].check) begin
                chk($sformatf("vec%0d outputs", i), act_o, tbl[i].exp_o);
                chk($sformatf("vec%0d retired", i), retired_o, tbl[i].exp_ret);
            end
            tick();
        end

        run_random(40);

        // Reset landing in the middle of a store's memory wait
        start_i = 1'b1; tick();
        start_i = 1'b0; instr_i = SW; imem_ready_i = 1'b1; tick();
        imem_ready_i = 1'b0; tick();
        tick();
        @(negedge clk);
        chk("sw mem dmem_we", dmem_we_o, 1'b1);
        chk("sw retired before reset nonzero", (retired_o != 0), 1'b1);
        tick();
        rst_i = 1'b0; tick();
        rst_i = 1'b1;
        @(negedge clk);
        chk("reset mid-mem outputs", act_o, Z);
        chk("reset mid-mem retired", retired_o, 0);
        tick();

        // Fetch never answered: trap after TIMEOUT waiting cycles
        do_reset();
        start_i = 1'b1; tick();
        start_i = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            chk($sformatf("imem wait %0d imem_re", i), act_o, mk(4'b1000, 10'd0, 4'd0, 5'd0, ST_B));
            tick();
        end
        @(negedge clk);
        chk("imem timeout trap", act_o, mk(4'b0000, 10'd0, 4'd0, 5'd0, 4'b0110));
        tick();
        start_i = 1'b1; tick();
        start_i = 1'b0;
        @(negedge clk);
        chk("imem trap ignores start", act_o, mk(4'b0000, 10'd0, 4'd0, 5'd0, 4'b0110));
        tick();

        // Ready arriving on the limit cycle wins over the timeout
        do_reset();
        start_i = 1'b1; tick();
        start_i = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        instr_i = ADDI; imem_ready_i = 1'b1; tick();
        imem_ready_i = 1'b0;
        @(negedge clk);
        chk("imem late ready decode", act_o, mk(4'b0000, IMM_ADDI, 4'd0, 5'd0, ST_B));
        tick();

        // Store never acknowledged: trap with the data-memory cause
        do_reset();
        start_i = 1'b1; tick();
        start_i = 1'b0; instr_i = SW; imem_ready_i = 1'b1; tick();
        imem_ready_i = 1'b0; tick();
        tick();
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            chk($sformatf("dmem wait %0d dmem_we", i), dmem_we_o, 1'b1);
            tick();
        end
        @(negedge clk);
        chk("dmem timeout trap", act_o, mk(4'b0000, 10'd0, 4'd0, 5'd0, 4'b0111));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
